// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bus: stall/branch inputs, memory address/data, and the
// captured instruction handed to decode. Optional FETCH_COUNT_EN adds
// the fetch_count counter output.
interface pc_fetch_unit_if #(
  parameter int unsigned PC_WIDTH   = 8,
  parameter int unsigned INSN_WIDTH = 8
);
  logic                  stall;
  logic                  branch_taken;
  logic [PC_WIDTH-1:0]   branch_target;
  logic [PC_WIDTH-1:0]   pc;
  logic [INSN_WIDTH-1:0] instruction;
  logic [INSN_WIDTH-1:0] ir;
  logic [PC_WIDTH-1:0]   ir_pc;
  logic                  ir_valid;
  logic                  halted;
`ifdef FETCH_COUNT_EN
  logic [15:0]           fetch_count;
`endif

  // Fetch unit side
  modport master (
    input  stall, branch_taken, branch_target, instruction,
    output pc, ir, ir_pc, ir_valid, halted
`ifdef FETCH_COUNT_EN
    , output fetch_count
`endif
  );

  // Memory / execute / decode side
  modport slave (
    output stall, branch_taken, branch_target, instruction,
    input  pc, ir, ir_pc, ir_valid, halted
`ifdef FETCH_COUNT_EN
    , input fetch_count
`endif
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns the PC, captures the combinational memory word into IR,
// handles stall, branch flush (one bubble) and a sticky halt opcode.
// Optional feature macro: FETCH_COUNT_EN (16-bit saturating capture counter).
module pc_fetch_unit #(
  parameter int unsigned                 PC_WIDTH    = 8,
  parameter int unsigned                 INSN_WIDTH  = 8,
  parameter logic [PC_WIDTH-1:0]         RESET_PC    = '0,
  parameter logic [INSN_WIDTH-1:0]       HALT_OPCODE = 8'hFF
) (
  input  logic                clk,
  input  logic                reset,
  pc_fetch_unit_if.master     bus
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  logic [0:0]            state_q,    state_d;
  logic [PC_WIDTH-1:0]   pc_q,       pc_d;
  logic [INSN_WIDTH-1:0] ir_q,       ir_d;
  logic [PC_WIDTH-1:0]   ir_pc_q,    ir_pc_d;
  logic                  ir_valid_q, ir_valid_d;
  logic                  capture;

  // Next-state: branch > stall > halt detect > sequential fetch while running
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    capture    = 1'b0;
    if (state_q == ST_RUN) begin
      if (bus.branch_taken) begin
        pc_d       = bus.branch_target;
        ir_valid_d = 1'b0;
      end else if (!bus.stall) begin
        capture    = 1'b1;
        ir_d       = bus.instruction;
        ir_pc_d    = pc_q;
        ir_valid_d = 1'b1;
        if (bus.instruction == HALT_OPCODE) begin
          state_d = ST_HALT;
        end else begin
          pc_d = pc_q + 1'b1;
        end
      end
    end else begin
      // Halt word is presented to decode exactly once, then withdrawn
      if (!bus.stall) begin
        ir_valid_d = 1'b0;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  assign bus.pc       = pc_q;
  assign bus.ir       = ir_q;
  assign bus.ir_pc    = ir_pc_q;
  assign bus.ir_valid = ir_valid_q;
  assign bus.halted   = (state_q == ST_HALT);

`ifdef FETCH_COUNT_EN
  logic [15:0] fetch_count_q, fetch_count_d;

  // Count fresh captures, saturating at all-ones
  always_comb begin
    fetch_count_d = fetch_count_q;
    if (capture && (fetch_count_q != '1)) begin
      fetch_count_d = fetch_count_q + 16'd1;
    end
  end

  // Counter register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count_q <= '0;
    end else begin
      fetch_count_q <= fetch_count_d;
    end
  end

  assign bus.fetch_count = fetch_count_q;
`else
  logic unused_capture;
  assign unused_capture = capture;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with a combinational memory model.
// Optional FETCH_COUNT_EN checks are compiled in when the macro is defined.
module tb_pc_fetch_unit;
  logic clk;
  logic reset;
  logic [7:0] mem [256];
  int unsigned total;
  int unsigned bad;

  pc_fetch_unit_if #(.PC_WIDTH(8), .INSN_WIDTH(8)) bus ();

  pc_fetch_unit #(
    .PC_WIDTH(8),
    .INSN_WIDTH(8),
    .RESET_PC(8'h00),
    .HALT_OPCODE(8'hFF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  assign bus.instruction = mem[bus.pc];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic [7:0] e_pc, input logic [7:0] e_ir,
                              input logic [7:0] e_irpc, input logic e_v, input logic e_h);
    check({tag, ".pc"},       16'(bus.pc),       16'(e_pc));
    check({tag, ".ir"},       16'(bus.ir),       16'(e_ir));
    check({tag, ".ir_pc"},    16'(bus.ir_pc),    16'(e_irpc));
    check({tag, ".ir_valid"}, 16'(bus.ir_valid), 16'(e_v));
    check({tag, ".halted"},   16'(bus.halted),   16'(e_h));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i + 8'h10);
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_target = 8'h00;

    // Reset state
    step();
    expect_state("reset", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    reset = 1'b0;

    // Sequential fetch
    for (int i = 0; i < 4; i++) begin
      step();
      expect_state("seq", 8'(i + 1), 8'(8'h10 + i), 8'(i), 1'b1, 1'b0);
    end
`ifdef FETCH_COUNT_EN
    check("count_seq", bus.fetch_count, 16'd4);
`endif

    // Stall at pc=5
    step();
    expect_state("pre_stall", 8'h05, 8'h14, 8'h04, 1'b1, 1'b0);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_state("stall", 8'h05, 8'h14, 8'h04, 1'b1, 1'b0);
    end
`ifdef FETCH_COUNT_EN
    check("count_stall", bus.fetch_count, 16'd5);
`endif
    bus.stall = 1'b0;
    step();
    expect_state("unstall", 8'h06, 8'h15, 8'h05, 1'b1, 1'b0);
    step();
    expect_state("to7", 8'h07, 8'h16, 8'h06, 1'b1, 1'b0);

    // Branch flush at pc=7 -> 0x40
    bus.branch_taken = 1'b1;
    bus.branch_target = 8'h40;
    step();
    expect_state("br", 8'h40, 8'h16, 8'h06, 1'b0, 1'b0);
    bus.branch_taken = 1'b0;
    step();
    expect_state("br_tgt", 8'h41, 8'h50, 8'h40, 1'b1, 1'b0);

    // Branch under stall to 0xFE, then wrap-around
    bus.branch_taken = 1'b1;
    bus.branch_target = 8'hFE;
    bus.stall = 1'b1;
    step();
    expect_state("br_stall", 8'hFE, 8'h50, 8'h40, 1'b0, 1'b0);
    bus.branch_taken = 1'b0;
    bus.stall = 1'b0;
    step();
    expect_state("wrap0", 8'hFF, 8'h0E, 8'hFE, 1'b1, 1'b0);
    step();
    expect_state("wrap1", 8'h00, 8'h0F, 8'hFF, 1'b1, 1'b0);
    step();
    expect_state("wrap2", 8'h01, 8'h10, 8'h00, 1'b1, 1'b0);

    // Branch to current pc still inserts a bubble
    bus.branch_taken = 1'b1;
    bus.branch_target = 8'h01;
    step();
    expect_state("br_self", 8'h01, 8'h10, 8'h00, 1'b0, 1'b0);

    // Branch + halt collision: branch wins
    mem[8'h30] = 8'hFF;
    bus.branch_target = 8'h30;
    step();
    check("coll_pre.pc", 16'(bus.pc), 16'h0030);
    bus.branch_target = 8'h20;
    step();
    expect_state("coll", 8'h20, 8'h10, 8'h00, 1'b0, 1'b0);
    bus.branch_taken = 1'b0;
    step();
    expect_state("coll_after", 8'h21, 8'h30, 8'h20, 1'b1, 1'b0);

    // Halt at address 3, reached from a mid-run reset
    mem[3] = 8'hFF;
    reset = 1'b1;
    step();
    expect_state("reset2", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step();
    expect_state("pre_halt", 8'h03, 8'h12, 8'h02, 1'b1, 1'b0);
    step();
    expect_state("halt", 8'h03, 8'hFF, 8'h03, 1'b1, 1'b1);
`ifdef FETCH_COUNT_EN
    check("count_halt", bus.fetch_count, 16'd4);
`endif
    bus.stall = 1'b1;
    step();
    expect_state("halt_stall", 8'h03, 8'hFF, 8'h03, 1'b1, 1'b1);
    bus.stall = 1'b0;
    step();
    expect_state("halt_drop", 8'h03, 8'hFF, 8'h03, 1'b0, 1'b1);
    bus.branch_taken = 1'b1;
    bus.branch_target = 8'h40;
    step();
    expect_state("halt_br", 8'h03, 8'hFF, 8'h03, 1'b0, 1'b1);
    bus.branch_taken = 1'b0;
    step();
    expect_state("halt_hold", 8'h03, 8'hFF, 8'h03, 1'b0, 1'b1);
`ifdef FETCH_COUNT_EN
    check("count_halt_hold", bus.fetch_count, 16'd4);
`endif
    reset = 1'b1;
    step();
    expect_state("reset3", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    reset = 1'b0;
    mem[3] = 8'h13;

    // Reset during stall applies full reset values
    step();
    bus.stall = 1'b1;
    reset = 1'b1;
    step();
    expect_state("reset_stall", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    reset = 1'b0;
    bus.stall = 1'b0;
    step();
    expect_state("post_reset", 8'h01, 8'h10, 8'h00, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
